// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Shared types and constants for the countdown controller and its decrementer.
//   cd_state_t    : controller state encoding (IDLE/RUN/PAUSE/DONE)
//   CD_W          : datapath width of the count register
//   CD_PRESC_W    : width of the optional tick prescaler
//   state_is_busy : decode of the "busy" status from a state value
// -----------------------------------------------------------------------------
package countdown_pkg;

    localparam int CD_W       = 16;
    localparam int CD_PRESC_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } cd_state_t;

    // A run is in progress while counting or frozen by pause.
    function automatic logic state_is_busy(input cd_state_t s);
        return (s == RUN) || (s == PAUSE);
    endfunction

endpackage

// File: rtl/decrement_16bit.sv
// -----------------------------------------------------------------------------
// decrement_16bit
// Combinational A - 1 with a signed-overflow indication.
//   A        in  16 : operand
//   decA     out 16 : A - 1 (wraps 0x0000 -> 0xFFFF)
//   overflow out 1  : two's-complement overflow, i.e. A == 0x8000
// -----------------------------------------------------------------------------
module decrement_16bit
    import countdown_pkg::*;
(
    input  logic [CD_W-1:0] A,
    output logic [CD_W-1:0] decA,
    output logic            overflow
);

    // borrow[i] is high when every bit below i is zero, so bit i flips.
    logic [CD_W:0] borrow;

    assign borrow[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < CD_W; gi = gi + 1) begin : g_borrow
            assign decA[gi]       = A[gi] ^ borrow[gi];
            assign borrow[gi + 1] = borrow[gi] & ~A[gi];
        end
    endgenerate

    // Subtracting a positive value can only overflow when a negative
    // operand produces a positive result (0x8000 -> 0x7FFF).
    assign overflow = A[CD_W-1] & ~decA[CD_W-1];

endmodule

// File: rtl/countdown_ctrl_16bit.sv
// -----------------------------------------------------------------------------
// countdown_ctrl_16bit
// Sequencing controller for the 16-bit decrementer datapath. A start value is
// accepted in IDLE, then decremented once per tick until it reaches zero, at
// which point a one-cycle done pulse is produced.
//
// Build option: define CD_PRESCALE_EN to insert an 8-bit prescaler so that a
// tick occurs every PRESCALE RUN cycles. Without it every RUN cycle is a tick.
//
// Parameters:
//   PRESCALE  : RUN cycles per tick when CD_PRESCALE_EN is defined (1..255)
// Ports:
//   clk       in  1  : clock, rising edge
//   rst       in  1  : synchronous active-high reset
//   start     in  1  : load request, honoured only while ready
//   load_val  in  16 : start value, sampled on the accepting edge
//   pause     in  1  : level, freezes counting
//   abort     in  1  : level, cancels a run without done
//   ready     out 1  : IDLE decode
//   busy      out 1  : RUN or PAUSE decode
//   count     out 16 : count register
//   done      out 1  : one-cycle pulse on natural completion
//   ovf_seen  out 1  : sticky, a committed decrement went 0x8000 -> 0x7FFF
// -----------------------------------------------------------------------------
module countdown_ctrl_16bit
    import countdown_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CD_W-1:0] load_val,
    input  logic            pause,
    input  logic            abort,
    output logic            ready,
    output logic            busy,
    output logic [CD_W-1:0] count,
    output logic            done,
    output logic            ovf_seen
);

    // Reject illegal prescale settings at elaboration time.
    generate
        if (PRESCALE < 1 || PRESCALE > 255) begin : g_prescale_range
            $error("countdown_ctrl_16bit: PRESCALE must be in 1..255");
        end
    endgenerate

    cd_state_t       state_reg, state_next;
    logic [CD_W-1:0] count_reg, count_next;
    logic            done_reg, done_next;
    logic            ovf_reg, ovf_next;
    logic            tick;

    logic [CD_W-1:0] dec_a;
    logic            dec_ovf;

    // The decrementer always sees the current count; its result is only
    // committed on a tick in RUN.
    decrement_16bit u_dec (
        .A        (count_reg),
        .decA     (dec_a),
        .overflow (dec_ovf)
    );

`ifdef CD_PRESCALE_EN
    localparam logic [CD_PRESC_W-1:0] PRESC_LAST = CD_PRESC_W'(PRESCALE - 1);

    logic [CD_PRESC_W-1:0] presc_reg, presc_next;

    assign tick = (presc_reg == PRESC_LAST);

    // Advances only in RUN cycles that are not abort/pause cycles, so it
    // holds through PAUSE and restarts from zero on every accepted start.
    always_comb begin
        presc_next = presc_reg;
        if (state_reg == IDLE && start) begin
            presc_next = '0;
        end else if (state_reg == RUN && !abort && !pause) begin
            presc_next = tick ? '0 : presc_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        done_next  = 1'b0;
        ovf_next   = ovf_reg;

        case (state_reg)
            IDLE: begin
                // abort and pause have no effect here.
                if (start) begin
                    count_next = load_val;
                    ovf_next   = 1'b0;
                    if (load_val == '0) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end

            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (pause) begin
                    state_next = PAUSE;
                end else if (tick) begin
                    if (count_reg == '0) begin
                        // Unreachable in normal use; never wrap below zero.
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        count_next = dec_a;
                        ovf_next   = ovf_reg | dec_ovf;
                        if (count_reg == CD_W'(1)) begin
                            state_next = DONE;
                            done_next  = 1'b1;
                        end
                    end
                end
            end

            PAUSE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (!pause) begin
                    state_next = RUN;
                end
            end

            DONE: begin
                // done_reg is high during this cycle; always return to IDLE.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            done_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            done_reg  <= done_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign ready    = (state_reg == IDLE);
    assign busy     = state_is_busy(state_reg);
    assign count    = count_reg;
    assign done     = done_reg;
    assign ovf_seen = ovf_reg;

endmodule

// File: tb/tb_countdown_ctrl_16bit.sv
// -----------------------------------------------------------------------------
// tb_countdown_ctrl_16bit
// Directed bench for countdown_ctrl_16bit. Each vector row gives the inputs
// applied before a rising edge and the outputs expected just after it.
// With CD_PRESCALE_EN defined the PRESCALE=4 timing sequence is run instead.
// -----------------------------------------------------------------------------
module tb_countdown_ctrl_16bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] load_val;
    logic        pause;
    logic        abort;
    logic        ready;
    logic        busy;
    logic [15:0] count;
    logic        done;
    logic        ovf_seen;

    always #5 clk = ~clk;

    countdown_ctrl_16bit #(.PRESCALE(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_val (load_val),
        .pause    (pause),
        .abort    (abort),
        .ready    (ready),
        .busy     (busy),
        .count    (count),
        .done     (done),
        .ovf_seen (ovf_seen)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic [15:0] load_val;
        logic        pause;
        logic        abort;
        logic [15:0] e_count;
        logic        e_done;
        logic        e_ready;
        logic        e_busy;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply inputs on the falling edge, then sample 1 time unit after the
    // following rising edge.
    task automatic drive(input logic r, input logic s, input logic [15:0] lv,
                         input logic p, input logic a);
        @(negedge clk);
        rst      = r;
        start    = s;
        load_val = lv;
        pause    = p;
        abort    = a;
        @(posedge clk);
        #1;
    endtask

    task automatic row(input logic r, input logic s, input logic [15:0] lv,
                       input logic p, input logic a,
                       input logic [15:0] ec, input logic ed, input logic erdy,
                       input logic ebsy, input logic eovf);
        vec_t v;
        v.rst = r; v.start = s; v.load_val = lv; v.pause = p; v.abort = a;
        v.e_count = ec; v.e_done = ed; v.e_ready = erdy; v.e_busy = ebsy; v.e_ovf = eovf;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] pack_out(input logic [15:0] c, input logic d,
                                             input logic r, input logic b, input logic o);
        return {12'h0, c, d, r, b, o};
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; load_val = '0; pause = 1'b0; abort = 1'b0;

`ifndef CD_PRESCALE_EN
        // ---- vector table ------------------------------------------------
        //  rst st load    p  a   count   dn rdy bsy ovf
        row(1, 0, 16'd0,  0, 0,  16'd0,  0, 1,  0,  0);
        row(1, 0, 16'd0,  0, 0,  16'd0,  0, 1,  0,  0);
        // load 3: count 3,2,1,0, done on the third tick
        row(0, 1, 16'd3,  0, 0,  16'd3,  0, 0,  1,  0);
        row(0, 0, 16'd0,  0, 0,  16'd2,  0, 0,  1,  0);
        row(0, 0, 16'd0,  0, 0,  16'd1,  0, 0,  1,  0);
        row(0, 0, 16'd0,  0, 0,  16'd0,  1, 0,  0,  0);
        row(0, 1, 16'd5,  0, 0,  16'd0,  0, 1,  0,  0);   // start in DONE ignored
        row(0, 0, 16'd0,  0, 0,  16'd0,  0, 1,  0,  0);
        // load 0: straight to DONE, back to IDLE (abort ignored in DONE)
        row(0, 1, 16'd0,  0, 0,  16'd0,  1, 0,  0,  0);
        row(0, 0, 16'd0,  0, 1,  16'd0,  0, 1,  0,  0);
        row(0, 0, 16'd0,  1, 1,  16'd0,  0, 1,  0,  0);   // pause/abort ignored in IDLE
        // load 10, pause high for 4 cycles after the 2nd tick
        row(0, 1, 16'd10, 0, 0,  16'd10, 0, 0,  1,  0);
        row(0, 0, 16'd0,  0, 0,  16'd9,  0, 0,  1,  0);
        row(0, 0, 16'd0,  0, 0,  16'd8,  0, 0,  1,  0);
        for (int k = 0; k < 4; k++)
            row(0, 0, 16'd0, 1, 0,  16'd8,  0, 0,  1,  0);
        row(0, 0, 16'd0,  0, 0,  16'd8,  0, 0,  1,  0);   // PAUSE -> RUN, no tick
        for (int k = 7; k >= 1; k--)
            row(0, 0, 16'd0, 0, 0, 16'(k), 0, 0,  1,  0);
        row(0, 0, 16'd0,  0, 0,  16'd0,  1, 0,  0,  0);   // done 15 edges after E0
        row(0, 0, 16'd0,  0, 0,  16'd0,  0, 1,  0,  0);
        // load 10, abort after 3 ticks; a start mid-run is ignored
        row(0, 1, 16'd10, 0, 0,  16'd10, 0, 0,  1,  0);
        row(0, 0, 16'd0,  0, 0,  16'd9,  0, 0,  1,  0);
        row(0, 1, 16'd99, 0, 0,  16'd8,  0, 0,  1,  0);
        row(0, 0, 16'd0,  0, 0,  16'd7,  0, 0,  1,  0);
        row(0, 0, 16'd0,  0, 1,  16'd7,  0, 1,  0,  0);
        row(0, 0, 16'd0,  0, 1,  16'd7,  0, 1,  0,  0);
        row(0, 0, 16'd0,  0, 0,  16'd7,  0, 1,  0,  0);
        // abort while paused
        row(0, 1, 16'd4,  0, 0,  16'd4,  0, 0,  1,  0);
        row(0, 0, 16'd0,  0, 0,  16'd3,  0, 0,  1,  0);
        row(0, 0, 16'd0,  1, 0,  16'd3,  0, 0,  1,  0);
        row(0, 0, 16'd0,  1, 1,  16'd3,  0, 1,  0,  0);
        // rst mid-run at count 5 overrides start/pause; no done afterwards
        row(0, 1, 16'd10, 0, 0,  16'd10, 0, 0,  1,  0);
        for (int k = 9; k >= 5; k--)
            row(0, 0, 16'd0, 0, 0, 16'(k), 0, 0,  1,  0);
        row(1, 1, 16'd3,  1, 0,  16'd0,  0, 1,  0,  0);
        row(0, 0, 16'd0,  0, 0,  16'd0,  0, 1,  0,  0);
        row(0, 0, 16'd0,  0, 0,  16'd0,  0, 1,  0,  0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].load_val, vecs[i].pause, vecs[i].abort);
            $display("vec %0d: count=%h done=%b ready=%b busy=%b ovf=%b", i,
                     count, done, ready, busy, ovf_seen);
            chk($sformatf("vec%0d", i),
                pack_out(count, done, ready, busy, ovf_seen),
                pack_out(vecs[i].e_count, vecs[i].e_done, vecs[i].e_ready,
                         vecs[i].e_busy, vecs[i].e_ovf));
        end

        // ---- 0x8001: overflow on the second tick, sticky through done ----
        begin
            int   cycles;
            logic ovf_all;
            logic got_done;
            drive(0, 1, 16'h8001, 0, 0);
            chk("ovf_load_count", {16'h0, count}, 32'h8001);
            drive(0, 0, 16'h0, 0, 0);
            chk("ovf_tick1", {15'h0, count, ovf_seen}, {15'h0, 16'h8000, 1'b0});
            drive(0, 0, 16'h0, 0, 0);
            chk("ovf_tick2", {15'h0, count, ovf_seen}, {15'h0, 16'h7FFF, 1'b1});
            $display("ovf run: count=%h ovf=%b", count, ovf_seen);
            cycles   = 0;
            ovf_all  = 1'b1;
            got_done = 1'b0;
            while (!got_done && cycles < 40000) begin
                drive(0, 0, 16'h0, 0, 0);
                cycles++;
                ovf_all = ovf_all & ovf_seen;
                if (done) got_done = 1'b1;
            end
            $display("ovf run: done after %0d more edges, count=%h ovf=%b", cycles, count, ovf_seen);
            chk("ovf_done_seen", {31'h0, got_done}, 32'h1);
            chk("ovf_done_latency", cycles, 32'd32767);
            chk("ovf_done_count", {16'h0, count}, 32'h0);
            chk("ovf_hold", {31'h0, ovf_all}, 32'h1);
            drive(0, 0, 16'h0, 0, 0);
            chk("ovf_idle", {30'h0, ready, ovf_seen}, 32'h3);
            drive(0, 1, 16'd3, 0, 0);
            $display("restart: count=%h ovf=%b", count, ovf_seen);
            chk("ovf_cleared", {15'h0, count, ovf_seen}, {15'h0, 16'd3, 1'b0});
        end
`else
        // ---- PRESCALE=4: load 2 gives done 8 edges after acceptance ------
        drive(1, 0, 16'h0, 0, 0);
        chk("ps_reset", pack_out(count, done, ready, busy, ovf_seen),
            pack_out(16'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        drive(0, 1, 16'd2, 0, 0);
        chk("ps_load", {16'h0, count}, 32'd2);
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 16'h0, 0, 0);
            $display("ps edge %0d: count=%h done=%b", k, count, done);
            chk($sformatf("ps_edge%0d", k), {15'h0, count, done},
                {15'h0, 16'(2 - k / 4), (k == 8) ? 1'b1 : 1'b0});
        end
        drive(0, 0, 16'h0, 0, 0);
        chk("ps_ready", {31'h0, ready}, 32'h1);
        // pause holds the prescaler: one pause cycle plus return adds 2 edges
        drive(0, 1, 16'd1, 0, 0);
        drive(0, 0, 16'h0, 0, 0);            // presc 0 -> 1
        drive(0, 0, 16'h0, 1, 0);            // to PAUSE, presc holds
        drive(0, 0, 16'h0, 0, 0);            // back to RUN
        drive(0, 0, 16'h0, 0, 0);            // presc 1 -> 2
        chk("ps_pause_hold", {15'h0, count, done}, {15'h0, 16'd1, 1'b0});
        drive(0, 0, 16'h0, 0, 0);            // presc 2 -> 3
        drive(0, 0, 16'h0, 0, 0);            // tick
        chk("ps_pause_done", {15'h0, count, done}, {15'h0, 16'd0, 1'b1});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl_16bit.md
# countdown_ctrl_16bit

Sequencing controller for the 16-bit decrementer datapath. It accepts a start value through a start handshake, then drives the decrementer once per tick until the count reaches zero. It reports busy, current count, a one-cycle done pulse and a sticky signed-overflow flag. Sits between software-visible control registers and the `decrement_16bit` datapath instance.

## Interface
- `PRESCALE`, 4: cycles per decrement tick; used only when `CD_PRESCALE_EN` is defined; legal range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: load request; honoured only when `ready`=1.
- `load_val` in 16: start value, sampled on the accepting edge.
- `pause` in 1: level; freezes counting while high.
- `abort` in 1: level; cancels a run without `done`.
- `ready` out 1: high in IDLE only.
- `busy` out 1: high in RUN or PAUSE.
- `count` out 16: current count register.
- `done` out 1: one-cycle pulse on natural completion.
- `ovf_seen` out 1: sticky; set when a committed decrement had decrementer `overflow`=1, i.e. count was 0x8000 going to 0x7FFF.

## Operation
- States are IDLE, RUN, PAUSE and DONE.
- Reset puts the block in IDLE with `count`=0, `done`=0, `ovf_seen`=0, `busy`=0 and `ready`=1. The prescaler is cleared.
- **IDLE, `start`=1:**
  - `count`←`load_val` and `ovf_seen`←0.
  - If `load_val`==0, the next state is DONE. Otherwise it is RUN.
- **IDLE, other inputs:** `abort` and `pause` are ignored.
- **RUN, per cycle, priority `abort` > `pause` > tick:**
  - If `abort`=1, go to IDLE with `count` held and no `done`.
  - Else if `pause`=1, go to PAUSE with `count` held.
  - Else on a tick, `count`←`decA` and `ovf_seen` |= decrementer `overflow`. If `count`==1, the next state is DONE.
- **PAUSE:**
  - If `abort`=1, go to IDLE.
  - Else if `pause`=0, go to RUN.
  - `count` and the prescaler hold.
- **DONE:**
  - `done`=1 for exactly this cycle, with `count`=0.
  - The next state is IDLE unconditionally; `abort` is ignored.
- `start` while not IDLE is ignored and not queued.
- Counting is unsigned down to 0 and never wraps below 0.
- The decrementer input is always `count`. Its output is used only on a committed tick.

## Timing
- Every output is registered, except `ready` and `busy`, which are decoded from the state register.
- **Without prescale:**
  - Start is accepted at edge E0.
  - `count` = N−k after edge E0+k.
  - `done` is high in the cycle following edge E0+N. `ready` returns after edge E0+N+1.
- **Load 0:** `done` is high in the cycle after E0. Total round trip is 2 cycles.
- **Pause:**
  - `pause` asserted in a RUN cycle suppresses that cycle's tick.
  - Each PAUSE cycle adds one cycle to the latency, plus one cycle for the return to RUN.
- **`rst` mid-run:** takes effect at the next edge and overrides all other inputs. No `done` is produced.
- **`abort`:** leaves `ovf_seen` and `count` readable until the next `start`.

## Configuration
- **`CD_PRESCALE_EN` defined:**
  - An 8-bit prescaler counts 0..`PRESCALE`−1 in RUN. A tick occurs when it equals `PRESCALE`−1, and it then wraps to 0.
  - It is cleared on start acceptance and holds in PAUSE.
  - Latency to `done` becomes N·`PRESCALE` cycles after E0.
- **`CD_PRESCALE_EN` undefined:** tick=1 every RUN cycle, no prescaler logic exists, and `PRESCALE` is unused.

## Structure
- **Package `countdown_pkg`:**
  - State enum typedef: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
  - Localparam `CD_W`=16.
  - Prescaler width localparam = 8.
- **Sub-module:** one instance of the existing `decrement_16bit` (ports `A`, `decA`, `overflow`). No other sub-modules.

## Test plan
- Reset then `start` with `load_val`=3:
  - `count` follows 3,2,1,0.
  - `done` pulses once, 3 cycles after acceptance.
  - `ovf_seen`=0 and `ready` returns.
- `start` with `load_val`=0 → `done` in the next cycle with `count`=0 and no RUN cycles.
- `start` with `load_val`=16'h8001:
  - After the second tick, `count`=16'h7FFF and `ovf_seen`=1.
  - `ovf_seen` stays 1 through `done`, then clears on the next `start`.
- `load_val`=10 with `pause` high for 4 cycles after the 2nd tick:
  - `count` holds at 8.
  - `done` arrives 5 cycles later than the unpaused run.
- `load_val`=10 with `abort` after 3 ticks:
  - IDLE with `count`=7 and no `done`.
  - A `start` issued during the run was ignored.
- `rst` asserted mid-run at `count`=5 → next cycle all outputs are at reset values. With `CD_PRESCALE_EN` and `PRESCALE`=4, `load_val`=2 gives `done` 8 cycles after acceptance.
